// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO, issue register and response register around the 8-bit ALU
// Optional accumulator chaining with result forwarding is enabled by defining ALU_ACC_FWD_EN.
module alu_issue_stage #(
   parameter int DATA_W     = 8,
   parameter int OP_W       = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [DATA_W-1:0]             cmd_a,
   input  logic [DATA_W-1:0]             cmd_b,
   input  logic [OP_W-1:0]               cmd_op,
`ifdef ALU_ACC_FWD_EN
   input  logic                          cmd_acc,
`endif
   output logic [DATA_W-1:0]             alu_operand1,
   output logic [DATA_W-1:0]             alu_operand2,
   output logic [OP_W-1:0]               alu_op,
   input  logic [DATA_W-1:0]             alu_result,
   input  logic                          alu_zero,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_W-1:0]             rsp_result,
   output logic                          rsp_zero,
   output logic                          rsp_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_a  [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_b  [FIFO_DEPTH];
   logic [OP_W-1:0]   mem_op [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              issue_v;
   logic              push;
   logic              pop;
   logic              rsp_free;
   logic              capture;
   logic              op_bad;
   logic [DATA_W-1:0] cap_result;
   logic              cap_zero;
   logic [DATA_W-1:0] next_operand1;

   assign cmd_ready  = (fifo_count < CW'(FIFO_DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign rsp_free   = !rsp_valid || rsp_ready;
   assign capture    = issue_v && rsp_free;
   assign pop        = (fifo_count != '0) && (!issue_v || capture);

   // Unsupported opcodes leave the ALU output undefined, so it is masked here.
   assign op_bad     = (alu_op >= OP_W'(4));
   assign cap_result = op_bad ? '0 : alu_result;
   assign cap_zero   = op_bad ? 1'b1 : alu_zero;

`ifdef ALU_ACC_FWD_EN
   logic              mem_acc [FIFO_DEPTH];
   logic [DATA_W-1:0] acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (capture) begin
         acc <= cap_result;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_acc[wr_ptr] <= cmd_acc;
      end
   end

   // Forward the result being captured this edge so chained commands need no bubble.
   assign next_operand1 = mem_acc[rd_ptr] ? (capture ? cap_result : acc) : mem_a[rd_ptr];
`else
   assign next_operand1 = mem_a[rd_ptr];
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= cmd_a;
         mem_b[wr_ptr]  <= cmd_b;
         mem_op[wr_ptr] <= cmd_op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_v      <= 1'b0;
         alu_operand1 <= '0;
         alu_operand2 <= '0;
         alu_op       <= '0;
      end else if (pop) begin
         issue_v      <= 1'b1;
         alu_operand1 <= next_operand1;
         alu_operand2 <= mem_b[rd_ptr];
         alu_op       <= mem_op[rd_ptr];
      end else if (capture) begin
         issue_v      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else if (capture) begin
         rsp_valid  <= 1'b1;
         rsp_result <= cap_result;
         rsp_zero   <= cap_zero;
         rsp_err    <= op_bad;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Command front-end for the 8-bit combinational ALU.
- Buffers ALU commands in a small FIFO and presents one command at a time on registered ALU operand/op outputs.
- Captures the ALU's combinational result and zero flag into a response register with a valid/ready handshake.
- Provides a registered, back-pressurable pipeline around the ALU so that the ALU's combinational path is bounded by flops on both sides.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- OP_W, 3, opcode width; must match the ALU.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_op  in  OP_W  opcode.
- alu_operand1  out  DATA_W  registered, to ALU operand1.
- alu_operand2  out  DATA_W  registered, to ALU operand2.
- alu_op  out  OP_W  registered, to ALU alu_op.
- alu_result  in  DATA_W  from ALU result.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  DATA_W  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  unsupported opcode.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - FIFO empty, fifo_count=0, issue_v=0, rsp_valid=0.
  - alu_operand1/2 = 0, alu_op = 3'b000.
  - rsp_result = 0, rsp_zero = 0, rsp_err = 0.
  - Reset mid-operation discards all queued, issued and held commands; no response is produced for them.
- Command accept:
  - cmd_ready = (fifo_count < FIFO_DEPTH); it never depends on cmd_valid.
  - Push occurs on a clock edge when cmd_valid && cmd_ready.
  - When full, cmd_ready=0, even if a pop occurs in the same cycle (no full-bypass).
- Issue register (internal issue_v plus the alu_* outputs):
  - rsp_free = !rsp_valid || rsp_ready.
  - capture = issue_v && rsp_free.
  - Load from the FIFO head when FIFO non-empty && (!issue_v || capture); the pop occurs at the same edge.
  - When nothing loads, the alu_* outputs hold their last values (stable under back-pressure).
  - issue_v clears on capture without a new load.
- Response register:
  - On capture: rsp_valid <= 1; rsp_result <= alu_result; rsp_zero <= alu_zero; rsp_err <= 0.
  - If alu_op >= 3'b100: rsp_result <= 0, rsp_zero <= 1, rsp_err <= 1. The ALU's X output is never captured.
  - rsp_valid clears when rsp_ready && !capture.
  - rsp_* are held stable while rsp_valid && !rsp_ready.
- Latency and throughput:
  - Command accepted at edge t0 is issued at t1; rsp_valid rises at t2.
  - Sustained 1 command/cycle with rsp_ready=1.
  - FIFO ordering is preserved end to end.
- Simultaneous push and pop on a non-full FIFO: fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Arithmetic is performed by the ALU only; this stage does no arithmetic on the data.

Optional Feature:
- Macro: ALU_ACC_FWD_EN.
- With the macro defined:
  - Adds input cmd_acc (1 bit), stored in the FIFO alongside each command.
  - Internal acc register: reset value 0; updated with every value written into rsp_result.
  - At issue, a command with cmd_acc=1 drives alu_operand1 from the accumulator instead of cmd_a. If a capture occurs on the same edge as the issue, alu_result is forwarded (masked value if alu_op >= 3'b100).
  - Back-to-back chained commands therefore run with no bubble.
- Without the macro: no cmd_acc port, no acc register, and alu_operand1 always comes from cmd_a.

Test Plan:
1. Reset, then push ADD 8'h05, 8'h03 with rsp_ready=1 -> rsp_valid at cycle 2 after accept, rsp_result=8'h08, rsp_zero=0, rsp_err=0.
2. SUB 8'h10, 8'h10 -> rsp_result=8'h00, rsp_zero=1.
3. rsp_ready=0; push 6 commands into FIFO_DEPTH=4:
   - cmd_ready drops after 4 FIFO entries + 1 issue + 1 response held.
   - fifo_count=4; alu_* and rsp_* stay stable.
   - Release rsp_ready -> 6 responses in order.
4. Opcode 3'b101 -> rsp_err=1, rsp_result=0, rsp_zero=1; the next ADD returns a correct result with rsp_err=0.
5. Assert rst_n low with 3 commands queued and rsp_valid=1 -> all outputs return to reset values immediately; no stale response after release.
6. (ALU_ACC_FWD_EN) ADD 1,2, then cmd_acc=1 ADD x,4, then cmd_acc=1 AND x,8'h06 back-to-back -> responses 8'h03, 8'h07, 8'h06.
